line_memory: RTL and testbench

//  Parametrised byte-addressed backing store behind the data cache. Accepts one request at a time

---
 rtl/mem_pkg.sv | 22 ++
 rtl/mem_byte_array.sv | 42 ++++
 rtl/line_memory.sv | 131 +++++++++++++
 tb/tb_line_memory.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and default geometry for the line-memory block.
// Modules recompute the derived sizes locally from their own parameters.
package mem_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam int DEF_WORD_W      = 32;
    localparam int DEF_LINE_WORDS  = 4;
    localparam int DEF_DEPTH_BYTES = 1024;

    localparam int LINE_W         = DEF_WORD_W * DEF_LINE_WORDS;
    localparam int BYTES_PER_WORD = DEF_WORD_W / 8;
    localparam int BYTES_PER_LINE = LINE_W / 8;
    localparam int OFF_W_WORD     = $clog2(BYTES_PER_WORD);
    localparam int OFF_W_LINE     = $clog2(BYTES_PER_LINE);
    localparam int IDX_W          = $clog2(DEF_DEPTH_BYTES);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Byte-wide storage with one byte-enabled word write port and one line read port.
// Big-endian: the lowest address byte sits in the most significant lane.
module mem_byte_array
    import mem_pkg::*;
#(
    parameter int WORD_W      = DEF_WORD_W,
    parameter int LINE_WORDS  = DEF_LINE_WORDS,
    parameter int DEPTH_BYTES = DEF_DEPTH_BYTES,
    localparam int WORD_BYTES = WORD_W / 8,
    localparam int LINE_BITS  = WORD_W * LINE_WORDS,
    localparam int LINE_BYTES = LINE_BITS / 8,
    localparam int MEM_IDX_W  = $clog2(DEPTH_BYTES)
) (
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [MEM_IDX_W-1:0]   wr_addr,
    input  logic [WORD_W-1:0]      wr_data,
    input  logic [WORD_BYTES-1:0]  wr_be,
    input  logic                   rd_en,
    input  logic [MEM_IDX_W-1:0]   rd_addr,
    output logic [LINE_BITS-1:0]   rd_line
);

    logic [7:0] mem [DEPTH_BYTES];

    // NOTE: storage is deliberately left out of reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int j = 0; j < WORD_BYTES; j++) begin
                if (wr_be[WORD_BYTES-1-j]) begin
                    mem[wr_addr + MEM_IDX_W'(j)] <= wr_data[WORD_W-1-8*j -: 8];
                end
            end
        end
        if (rd_en) begin
            for (int i = 0; i < LINE_BYTES; i++) begin
                rd_line[LINE_BITS-1-8*i -: 8] <= mem[rd_addr + MEM_IDX_W'(i)];
            end
        end
    end

endmodule

// File: rtl/line_memory.sv
// Latency-programmable backing store: one outstanding word write or line read,
// valid/ready request side, held response until consumed.
module line_memory
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int WORD_W      = DEF_WORD_W,
    parameter int LINE_WORDS  = DEF_LINE_WORDS,
    parameter int DEPTH_BYTES = DEF_DEPTH_BYTES,
    parameter int READ_LAT    = 5,
    parameter int WRITE_LAT   = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_write,
    input  logic [ADDR_W-1:0]              req_addr,
    input  logic [WORD_W-1:0]              req_wdata,
    input  logic [WORD_W/8-1:0]            req_be,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic                           rsp_write,
    output logic [WORD_W*LINE_WORDS-1:0]   rsp_line
);

    localparam int LINE_BITS  = WORD_W * LINE_WORDS;
    localparam int WORD_BYTES = WORD_W / 8;
    localparam int LINE_BYTES = LINE_BITS / 8;
    localparam int MEM_IDX_W  = $clog2(DEPTH_BYTES);
    localparam int CNT_W      = $clog2(max2(READ_LAT, WRITE_LAT) + 1);

    localparam logic [MEM_IDX_W-1:0] WORD_MASK = ~MEM_IDX_W'(WORD_BYTES - 1);
    localparam logic [MEM_IDX_W-1:0] LINE_MASK = ~MEM_IDX_W'(LINE_BYTES - 1);
    localparam logic [CNT_W-1:0]     RD_CNT    = CNT_W'(READ_LAT);
    localparam logic [CNT_W-1:0]     WR_CNT    = CNT_W'(WRITE_LAT);

    state_t                 state_q, state_n;
    logic [CNT_W-1:0]       cnt_q;
    logic                   write_q;
    logic [MEM_IDX_W-1:0]   addr_q;
    logic [WORD_W-1:0]      wdata_q;
    logic [WORD_BYTES-1:0]  be_q;
    logic                   accept, done, rsp_fire;
    logic [MEM_IDX_W-1:0]   req_idx;
    logic [LINE_BITS-1:0]   rd_line;
    logic                   unused_addr_hi;

    // Addresses wrap modulo the storage size; upper bits carry no meaning here.
    assign req_idx        = req_addr[MEM_IDX_W-1:0];
    assign unused_addr_hi = ^req_addr[ADDR_W-1:MEM_IDX_W];

    assign accept   = req_valid && (state_q == IDLE);
    assign done     = (state_q == BUSY) && (cnt_q == (write_q ? WR_CNT : RD_CNT));
    assign rsp_fire = (state_q == RESP) && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_n;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_n   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_write = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_n = BUSY;
            end
            BUSY: begin
                if (done) state_n = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_write = write_q;
                if (rsp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (accept) begin
            write_q <= req_write;
            addr_q  <= req_idx & (req_write ? WORD_MASK : LINE_MASK);
            wdata_q <= req_wdata;
            be_q    <= req_be;
        end
    end

    // Counter holds at its ceiling rather than wrapping back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= CNT_W'(1);
        end else if ((state_q == BUSY) && !done && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end else if (rsp_fire) begin
            cnt_q <= '0;
        end
    end

    // The array's read register only reloads on the next read, so the line stays put
    // under backpressure; gating by state forces zero for acks and during reset.
    assign rsp_line = (rsp_valid && !rsp_write) ? rd_line : '0;

    mem_byte_array #(
        .WORD_W      (WORD_W),
        .LINE_WORDS  (LINE_WORDS),
        .DEPTH_BYTES (DEPTH_BYTES)
    ) u_array (
        .clk     (clk),
        .wr_en   (done && write_q),
        .wr_addr (addr_q),
        .wr_data (wdata_q),
        .wr_be   (be_q),
        .rd_en   (done && !write_q),
        .rd_addr (addr_q),
        .rd_line (rd_line)
    );

endmodule

// File: tb/tb_line_memory.sv
// Directed bench for line_memory: default geometry instance plus an 8-word-line,
// 1/3-cycle-latency instance sharing the request bus.
module tb_line_memory;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              valid_a, valid_b, req_write, rsp_ready;
    logic [31:0]       req_addr, req_wdata;
    logic [3:0]        req_be;
    logic              ready_a, ready_b, rvalid_a, rvalid_b, rwrite_a, rwrite_b;
    logic [LINE_W-1:0] line_a;
    logic [255:0]      line_b;

    int checks = 0;
    int errors = 0;

    line_memory #(
        .ADDR_W(32), .WORD_W(32), .LINE_WORDS(4), .DEPTH_BYTES(1024),
        .READ_LAT(5), .WRITE_LAT(1)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(valid_a), .req_ready(ready_a), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rvalid_a), .rsp_ready(rsp_ready), .rsp_write(rwrite_a),
        .rsp_line(line_a)
    );

    line_memory #(
        .ADDR_W(32), .WORD_W(32), .LINE_WORDS(8), .DEPTH_BYTES(1024),
        .READ_LAT(1), .WRITE_LAT(3)
    ) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(valid_b), .req_ready(ready_b), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rvalid_b), .rsp_ready(rsp_ready), .rsp_write(rwrite_b),
        .rsp_line(line_b)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge after the response handshake.
    task automatic op(input bit b, input logic w, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] be,
                      output logic [255:0] line, output logic kind, output int lat);
        req_write = w; req_addr = addr; req_wdata = data; req_be = be;
        if (b) valid_b = 1'b1; else valid_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_a = 1'b0; valid_b = 1'b0;
        req_write = ~w; req_addr = addr ^ 32'h0000_03F0; req_wdata = ~data; req_be = ~be;
        lat = 0;
        while ((b ? rvalid_b : rvalid_a) !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        kind = b ? rwrite_b : rwrite_a;
        line = b ? line_b : {128'h0, line_a};
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic wr(input bit b, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] be, input int exp_lat, input string tag);
        logic [255:0] line;
        logic         kind;
        int           lat;
        op(b, 1'b1, addr, data, be, line, kind, lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_kind"}, kind, 1'b1);
        check({tag, "_line0"}, line, '0);
    endtask

    task automatic rd(input bit b, input logic [31:0] addr, input int exp_lat,
                      input string tag, output logic [255:0] line);
        logic kind;
        int   lat;
        op(b, 1'b0, addr, 32'h0, 4'h0, line, kind, lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_kind"}, kind, 1'b0);
    endtask

    task automatic watch_silence(input string tag);
        logic seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (rvalid_a === 1'b1 || rvalid_b === 1'b1) seen = 1'b1;
        end
        check(tag, seen, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [255:0] line, exp8;
        logic [127:0] held;
        logic         stable;
        int           lat;

        valid_a = 1'b0; valid_b = 1'b0; req_write = 1'b0; rsp_ready = 1'b0;
        req_addr = '0; req_wdata = '0; req_be = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_req_ready", ready_a, 1'b1);
        check("rst_rsp_valid", rvalid_a, 1'b0);
        check("rst_rsp_write", rwrite_a, 1'b0);
        check("rst_rsp_line", line_a, '0);

        wr(1'b0, 32'h40, 32'h0102_0304, 4'hF, 1, "seed40");

        // Write abandoned by reset before its commit edge.
        req_write = 1'b1; req_addr = 32'h40; req_wdata = 32'hFFFF_FFFF; req_be = 4'hF;
        valid_a = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0; valid_a = 1'b0;
        #1;
        check("abort_wr_ready", ready_a, 1'b1);
        check("abort_wr_valid", rvalid_a, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        watch_silence("abort_wr_silent");

        // Read abandoned mid-BUSY.
        req_write = 1'b0; req_addr = 32'h40; valid_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_a = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_rd_ready", ready_a, 1'b1);
        check("abort_rd_valid", rvalid_a, 1'b0);
        check("abort_rd_line", line_a, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        watch_silence("abort_rd_silent");

        rd(1'b0, 32'h40, 5, "rd40", line);
        check("rd40_kept", line[127:96], 32'h0102_0304);

        wr(1'b0, 32'h10, 32'hDEAD_BEEF, 4'hF, 1, "wr10");
        rd(1'b0, 32'h1C, 5, "rd1c", line);
        check("rd1c_word", line[127:96], 32'hDEAD_BEEF);

        wr(1'b0, 32'h20, 32'h1122_3344, 4'hF, 1, "fill20");
        wr(1'b0, 32'h20, 32'hAABB_CCDD, 4'b0101, 1, "be20");
        wr(1'b0, 32'h24, 32'h5566_7788, 4'hF, 1, "wr24");
        wr(1'b0, 32'h28, 32'h99AA_BBCC, 4'hF, 1, "wr28");
        wr(1'b0, 32'h2C, 32'hDDEE_FF00, 4'hF, 1, "wr2c");
        wr(1'b0, 32'h20, 32'hFFFF_FFFF, 4'h0, 1, "be0");

        // Backpressure on a read response for 7 cycles.
        req_write = 1'b0; req_addr = 32'h2C; valid_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_a = 1'b0;
        lat = 0;
        while (rvalid_a !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("bp_lat", lat, 5);
        held = line_a;
        stable = 1'b1;
        repeat (7) begin
            @(negedge clk);
            if (rvalid_a !== 1'b1 || line_a !== held || ready_a !== 1'b0) stable = 1'b0;
        end
        check("bp_stable", stable, 1'b1);
        check("bp_line", held, 128'h11BB33DD_55667788_99AABBCC_DDEEFF00);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("bp_done_valid", rvalid_a, 1'b0);
        check("bp_done_ready", ready_a, 1'b1);

        wr(1'b0, 32'h403, 32'hCAFE_F00D, 4'hF, 1, "wrap403");
        wr(1'b0, 32'hFFFF_FC04, 32'h1234_5678, 4'hF, 1, "wraphi");
        rd(1'b0, 32'h00F, 5, "rd00f", line);
        check("rd00f_words", line[127:64], 64'hCAFEF00D_12345678);

        // Wide-line instance, back-to-back writes then read.
        exp8 = '0;
        for (int i = 0; i < 8; i++) begin
            wr(1'b1, 32'h40 + 32'(4 * i), 32'hA5A5_0000 + 32'(i * 257), 4'hF, 3,
               $sformatf("w8_%0d", i));
            exp8 = {exp8[223:0], 32'hA5A5_0000 + 32'(i * 257)};
        end
        rd(1'b1, 32'h5B, 1, "rd8", line);
        check("rd8_line", line, exp8);
        wr(1'b1, 32'h44, 32'h0000_00EE, 4'b0001, 3, "w8_be");
        rd(1'b1, 32'h40, 1, "rd8b", line);
        check("rd8b_word1", line[223:192], 32'hA5A5_01EE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
